// File: rtl/ysyx_22040632_mem_arb.sv
// IFU/LSU arbiter and single-outstanding memory transaction sequencer.
// Define YSYX_22040632_MEMARB_RR_EN for round-robin arbitration instead of LSU priority with an IFU starvation guard.
module ysyx_22040632_mem_arb #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_rsp_valid,
  input  logic                if_rsp_ready,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic                ls_req_wen,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wmask,
  output logic                ls_rsp_valid,
  input  logic                ls_rsp_ready,
  output logic [DATA_W-1:0]   ls_rsp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  output logic                busy,
  output logic                owner
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic              grant_if, grant_ls, accept, ls_wins_tie;
  logic [DATA_W-1:0] rsp_buf;

`ifdef YSYX_22040632_MEMARB_RR_EN
  logic rr_ptr;

  // On a tie the requester the pointer does not name wins.
  assign ls_wins_tie = ~rr_ptr;

  always_ff @(posedge clk) begin
    if (rst)         rr_ptr <= 1'b1;
    else if (accept) rr_ptr <= grant_ls;
  end
`else
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;

  // LSU keeps priority until IFU has been passed over STARVE_MAX times in a row.
  assign ls_wins_tie = (starve_cnt != CNT_W'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (accept) begin
      if (grant_if)
        starve_cnt <= '0;
      else if (if_req_valid && (starve_cnt != CNT_W'(STARVE_MAX)))
        starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`endif

  assign grant_ls = ls_req_valid && (!if_req_valid || ls_wins_tie);
  assign grant_if = if_req_valid && !grant_ls;
  assign accept   = (state == IDLE) && (grant_if || grant_ls);

  assign if_rsp_data = rsp_buf;
  assign ls_rsp_data = rsp_buf;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    if_rsp_valid  = 1'b0;
    ls_rsp_valid  = 1'b0;
    busy          = 1'b1;
    case (state)
      IDLE: begin
        busy         = 1'b0;
        if_req_ready = grant_if;
        ls_req_ready = grant_ls;
        if (grant_if || grant_ls) state_nxt = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid) state_nxt = RESP;
      end
      RESP: begin
        if (owner) begin
          ls_rsp_valid = 1'b1;
          if (ls_rsp_ready) state_nxt = IDLE;
        end else begin
          if_rsp_valid = 1'b1;
          if (if_rsp_ready) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured only at the grant; the response only while waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner         <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      rsp_buf       <= '0;
    end else begin
      if (accept) begin
        owner         <= grant_ls;
        mem_req_addr  <= grant_ls ? ls_req_addr : if_req_addr;
        mem_req_wen   <= grant_ls & ls_req_wen;
        mem_req_wdata <= grant_ls ? ls_req_wdata : '0;
        mem_req_wmask <= grant_ls ? ls_req_wmask : STRB_W'(0);
      end
      if ((state == WAIT) && mem_rsp_valid) rsp_buf <= mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_ysyx_22040632_mem_arb.sv
// Self-checking bench for ysyx_22040632_mem_arb: directed scenarios plus randomized
// transactions against a transaction-level arbitration model.
module tb_ysyx_22040632_mem_arb;
  localparam int unsigned ADDR_W     = 64;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned STRB_W     = DATA_W / 8;
  localparam int unsigned STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready;
  logic [ADDR_W-1:0] if_req_addr;
  logic [DATA_W-1:0] if_rsp_data;
  logic              ls_req_valid, ls_req_ready, ls_req_wen, ls_rsp_valid, ls_rsp_ready;
  logic [ADDR_W-1:0] ls_req_addr;
  logic [DATA_W-1:0] ls_req_wdata, ls_rsp_data;
  logic [STRB_W-1:0] ls_req_wmask;
  logic              mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata, mem_rsp_data;
  logic [STRB_W-1:0] mem_req_wmask;
  logic              busy, owner;

  int n_checks = 0;
  int n_fail   = 0;

  // Arbitration history kept as plain counters: consecutive IFU pass-overs and last winner.
  int model_passed_over = 0;
  bit model_last_ls     = 1'b1;

  ysyx_22040632_mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_req_wen(ls_req_wen), .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_ready(ls_rsp_ready), .ls_rsp_data(ls_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    model_passed_over = 0;
    model_last_ls     = 1'b1;
  endtask

  // Decide who should win given who is asking, then update the history.
  task automatic model_arbitrate(input bit iv, input bit lv, output bit win_ls);
`ifdef YSYX_22040632_MEMARB_RR_EN
    if (iv && lv) win_ls = !model_last_ls;
    else          win_ls = lv;
    model_last_ls = win_ls;
`else
    if (iv && lv) win_ls = (model_passed_over < STARVE_MAX);
    else          win_ls = lv;
    if (!win_ls)  model_passed_over = 0;
    else if (iv)  model_passed_over = (model_passed_over + 1 > STARVE_MAX) ? STARVE_MAX
                                                                           : model_passed_over + 1;
`endif
  endtask

  task automatic check_idle_quiet(input string tag);
    chk_b({tag, "_busy"}, busy, 1'b0);
    chk_b({tag, "_mem_req_valid"}, mem_req_valid, 1'b0);
    chk_b({tag, "_if_rsp_valid"}, if_rsp_valid, 1'b0);
    chk_b({tag, "_ls_rsp_valid"}, ls_rsp_valid, 1'b0);
  endtask

  // One full transaction, entered and left in IDLE at posedge+1.
  task automatic run_txn(input bit iv, input bit lv, input logic [63:0] ia, input logic [63:0] la,
                         input bit lw, input logic [63:0] lwd, input logic [7:0] lm,
                         input int dly, input logic [63:0] rd, input int hold, output bit win_ls);
    logic [63:0] e_addr, e_wdata;
    logic [7:0]  e_mask;
    bit          e_wen;
    model_arbitrate(iv, lv, win_ls);
    e_addr  = win_ls ? la : ia;
    e_wen   = win_ls && lw;
    e_wdata = win_ls ? lwd : 64'h0;
    e_mask  = win_ls ? lm : 8'h0;

    if_req_valid = iv; if_req_addr = ia;
    ls_req_valid = lv; ls_req_addr = la; ls_req_wen = lw; ls_req_wdata = lwd; ls_req_wmask = lm;
    #1;
    chk_b("if_req_ready", if_req_ready, iv && !win_ls);
    chk_b("ls_req_ready", ls_req_ready, win_ls);
    step();

    // Requesters move on immediately; the transaction must keep the granted fields.
    if_req_addr  = ia + 64'h4;
    ls_req_addr  = {$urandom, $urandom};
    ls_req_wen   = ~lw;
    ls_req_wdata = {$urandom, $urandom};
    ls_req_wmask = ~lm;
    for (int i = 0; i <= dly; i++) begin
      if_req_valid = 1'($urandom);
      ls_req_valid = 1'($urandom);
      #1;
      chk_b("req_mem_req_valid", mem_req_valid, 1'b1);
      chk_w("req_mem_req_addr", mem_req_addr, e_addr);
      chk_b("req_mem_req_wen", mem_req_wen, e_wen);
      chk_w("req_mem_req_wdata", mem_req_wdata, e_wdata);
      chk_w("req_mem_req_wmask", 64'(mem_req_wmask), 64'(e_mask));
      chk_b("req_owner", owner, win_ls);
      chk_b("req_busy", busy, 1'b1);
      chk_b("req_if_req_ready", if_req_ready, 1'b0);
      chk_b("req_ls_req_ready", ls_req_ready, 1'b0);
      mem_req_ready = (i == dly);
      step();
      mem_req_ready = 1'b0;
    end

    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    #1;
    chk_b("wait_mem_req_valid", mem_req_valid, 1'b0);
    chk_b("wait_if_rsp_valid", if_rsp_valid, 1'b0);
    chk_b("wait_ls_rsp_valid", ls_rsp_valid, 1'b0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = rd;
    step();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = {$urandom, $urandom};

    for (int h = 0; h <= hold; h++) begin
      #1;
      chk_b("resp_if_rsp_valid", if_rsp_valid, !win_ls);
      chk_b("resp_ls_rsp_valid", ls_rsp_valid, win_ls);
      chk_w("resp_data", win_ls ? ls_rsp_data : if_rsp_data, rd);
      chk_b("resp_owner", owner, win_ls);
      chk_b("resp_busy", busy, 1'b1);
      if (h < hold) begin
        if_rsp_ready  = win_ls;
        ls_rsp_ready  = !win_ls;
        mem_rsp_valid = 1'($urandom);
      end else begin
        if_rsp_ready  = !win_ls;
        ls_rsp_ready  = win_ls;
        mem_rsp_valid = 1'b0;
      end
      step();
      if_rsp_ready  = 1'b0;
      ls_rsp_ready  = 1'b0;
      mem_rsp_valid = 1'b0;
    end
    #1;
    check_idle_quiet("done");
  endtask

  initial begin
    bit w;
    bit grants[$];
    rst = 1'b1;
    if_req_valid = 1'b0; if_req_addr = '0; if_rsp_ready = 1'b0;
    ls_req_valid = 1'b0; ls_req_addr = '0; ls_req_wen = 1'b0; ls_req_wdata = '0; ls_req_wmask = '0;
    ls_rsp_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    step();
    step();
    check_idle_quiet("reset");
    chk_b("reset_owner", owner, 1'b0);
    chk_b("reset_if_req_ready", if_req_ready, 1'b0);
    chk_b("reset_ls_req_ready", ls_req_ready, 1'b0);
    chk_w("reset_mem_req_addr", mem_req_addr, 64'h0);
    chk_w("reset_if_rsp_data", if_rsp_data, 64'h0);
    chk_w("reset_ls_rsp_data", ls_rsp_data, 64'h0);
    rst = 1'b0;
    model_reset();

    // Plain IFU fetch, then a stalled LSU store.
    run_txn(1, 0, 64'h8000_0000, 64'h0, 0, 64'h0, 8'h00, 0, 64'h0000_0413, 0, w);
    chk_b("ifu_fetch_winner", w, 1'b0);
    run_txn(0, 1, 64'h0, 64'h8000_1000, 1, 64'hDEAD_BEEF, 8'h0F, 3, 64'h1234_5678, 0, w);
    chk_b("lsu_store_winner", w, 1'b1);

    // Both requesting back to back.
    for (int k = 0; k < 10; k++) begin
      run_txn(1, 1, 64'h8000_2000 + 64'(k * 8), 64'h8000_3000 + 64'(k * 8), 0, 64'h0, 8'hFF,
              0, 64'(k) + 64'hA0, 0, w);
      grants.push_back(w);
    end
`ifdef YSYX_22040632_MEMARB_RR_EN
    chk_b("rr_first_grant", grants[0], 1'b0);
    chk_b("rr_second_grant", grants[1], 1'b1);
`else
    chk_b("fixed_grant_1", grants[0], 1'b1);
    chk_b("fixed_grant_4", grants[3], 1'b1);
    chk_b("fixed_grant_5", grants[4], 1'b0);
    chk_b("fixed_grant_6", grants[5], 1'b1);
`endif

    // Backpressured IFU response with stray memory pulses.
    run_txn(1, 0, 64'h8000_0040, 64'h0, 0, 64'h0, 8'h00, 1, 64'hCAFE_F00D_0000_0001, 5, w);

    // Reset while waiting on memory; the late response must vanish.
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0080;
    step();
    if_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h5555_AAAA_5555_AAAA;
    #1;
    check_idle_quiet("rst_wait");
    chk_w("rst_wait_addr", mem_req_addr, 64'h0);
    step();
    mem_rsp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_idle_quiet("rst_after");
      step();
    end

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      bit iv, lv;
      iv = 1'($urandom);
      lv = 1'($urandom);
      if (!iv && !lv) iv = 1'b1;
      run_txn(iv, lv, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
              {$urandom, $urandom}, 8'($urandom), int'($urandom_range(0, 3)),
              {$urandom, $urandom}, int'($urandom_range(0, 3)), w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
